echo_unit: RTL and testbench

- Audio echo effect for the music-synth sample path, placed after the sine_reader tone source.
- For each accepted signed 16-bit sample, outputs the input plus an attenuated copy of the output from D samples earlier. The echo is recursive.
- Delay D and attenuation are stepped at run time by one-shot control inputs.

---
 rtl/echo_unit.sv | 129 ++++++++++++
 tb/tb_echo_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_unit.sv
// Recursive audio echo: out = in + (out delayed D samples) >>> (h_idx+1), D stepped in quarter-RAM steps.
// Build option: define ECHO_SATURATE_EN to clamp the sum to 16 bits; otherwise it wraps.
module echo_unit #(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] sample_in,
    input  logic               in_ready,
    input  logic               next_D,
    input  logic               next_H,
    output logic signed [15:0] out,
    output logic               out_ready
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_W-1:0]       r_clr_addr;
    logic [ADDR_W-1:0]       r_wp;
    logic [1:0]              r_d_idx;
    logic [1:0]              r_h_idx;
    logic                    r_next_d_q;
    logic                    r_next_h_q;
    logic signed [15:0]      r_out;
    logic                    r_out_ready;
    logic signed [15:0]      r_mem [DEPTH];

    logic [1:0]              w_d_step;
    logic [ADDR_W-1:0]       w_rd_addr;
    logic [2:0]              w_shamt;
    logic signed [15:0]      w_delayed;
    logic signed [15:0]      w_echo;
    logic signed [15:0]      w_sum;
    logic                    w_accept;
    logic                    w_we;
    logic [ADDR_W-1:0]       w_waddr;
    logic signed [15:0]      w_wdata;

    // D = (d_idx+1)*DEPTH/4; the 2-bit step wraps to 0 at D = DEPTH, making rd = wp.
    assign w_d_step  = r_d_idx + 2'd1;
    assign w_rd_addr = r_wp - {w_d_step, {(ADDR_W-2){1'b0}}};
    assign w_delayed = r_mem[w_rd_addr];
    assign w_shamt   = {1'b0, r_h_idx} + 3'd1;
    assign w_echo    = w_delayed >>> w_shamt;

`ifdef ECHO_SATURATE_EN
    logic signed [16:0] w_sum17;
    assign w_sum17 = {sample_in[15], sample_in} + {w_echo[15], w_echo};

    always_comb begin
        if (w_sum17[16] != w_sum17[15]) begin
            w_sum = w_sum17[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            w_sum = w_sum17[15:0];
        end
    end
`else
    assign w_sum = sample_in + w_echo;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_addr == {ADDR_W{1'b1}}) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_we     = 1'b0;
        w_waddr  = r_wp;
        w_wdata  = w_sum;
        case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                w_wdata = '0;
            end
            ST_RUN: begin
                w_accept = in_ready;
                w_we     = in_ready;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr_addr  <= '0;
            r_wp        <= '0;
            r_d_idx     <= '0;
            r_h_idx     <= '0;
            r_next_d_q  <= 1'b0;
            r_next_h_q  <= 1'b0;
            r_out       <= '0;
            r_out_ready <= 1'b0;
        end else begin
            if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
            r_next_d_q  <= next_D;
            r_next_h_q  <= next_H;
            if (next_D && !r_next_d_q) r_d_idx <= r_d_idx + 2'd1;
            if (next_H && !r_next_h_q) r_h_idx <= r_h_idx + 2'd1;
            r_out_ready <= w_accept;
            if (w_accept) begin
                r_out <= w_sum;
                r_wp  <= r_wp + 1'b1;
            end
        end
    end

    // NOTE: the delay RAM has no reset; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    assign out       = r_out;
    assign out_ready = r_out_ready;
endmodule

// File: tb/tb_echo_unit.sv
// Self-checking bench for echo_unit: randomized and directed stimulus against a history-based echo model.
// The model honours ECHO_SATURATE_EN the same way the build does.
module tb_echo_unit;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sample_in = '0;
    logic        in_ready = 1'b0;
    logic        next_D = 1'b0;
    logic        next_H = 1'b0;
    logic [15:0] out;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model: every output since CLEAR, plus the current settings.
    logic [15:0] m_outs[$];
    int          m_d, m_h, m_clear_left;
    logic        m_prev_d, m_prev_h;
    logic [15:0] m_last;

    echo_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_in (sample_in),
        .in_ready  (in_ready),
        .next_D    (next_D),
        .next_H    (next_H),
        .out       (out),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        m_outs.delete();
        m_d = 0;
        m_h = 0;
        m_clear_left = DEPTH;
        m_prev_d = 1'b0;
        m_prev_h = 1'b0;
        m_last = '0;
    endfunction

    function automatic logic [15:0] model_sum(input logic [15:0] s);
        int n, dd, delayed, echo, sum;
        n = m_outs.size();
        dd = (m_d + 1) * (DEPTH / 4);
        delayed = (n >= dd) ? int'($signed(m_outs[n-dd])) : 0;
        echo = delayed >>> (m_h + 1);
        sum = int'($signed(s)) + echo;
`ifdef ECHO_SATURATE_EN
        if (sum > 32767) sum = 32767;
        else if (sum < -32768) sum = -32768;
`endif
        return sum[15:0];
    endfunction

    // One clock of stimulus; returns what the DUT shows and what the model predicts.
    task automatic tick(input logic v, input logic [15:0] s, input logic nd, input logic nh,
                        output logic [15:0] got, output logic got_rdy,
                        output logic [15:0] exp, output logic exp_rdy);
        logic rise_d, rise_h;
        in_ready  = v;
        sample_in = s;
        next_D    = nd;
        next_H    = nh;
        rise_d = nd && !m_prev_d;
        rise_h = nh && !m_prev_h;
        m_prev_d = nd;
        m_prev_h = nh;
        if (m_clear_left > 0) begin
            m_clear_left--;
            exp = m_last;
            exp_rdy = 1'b0;
        end else if (v) begin
            exp = model_sum(s);
            m_outs.push_back(exp);
            m_last = exp;
            exp_rdy = 1'b1;
        end else begin
            exp = m_last;
            exp_rdy = 1'b0;
        end
        if (rise_d) m_d = (m_d + 1) % 4;
        if (rise_h) m_h = (m_h + 1) % 4;
        @(posedge clk);
        #1;
        got = out;
        got_rdy = out_ready;
    endtask

    task automatic reset_and_clear();
        logic [15:0] got, exp;
        logic rdy, erdy;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        next_D = 1'b0;
        next_H = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) tick(1'b0, 16'h0, 1'b0, 1'b0, got, rdy, exp, erdy);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0 || out_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out=%h out_ready=%b, want 0000/0", out, out_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out !== 16'h0 || out_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: out=%h out_ready=%b, want 0000/0", out, out_ready);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_clear_latency();
        logic [15:0] got, exp, s;
        logic rdy, erdy;
        int first = -1;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            s = 16'($urandom);
            tick(1'b1, s, 1'b0, 1'b0, got, rdy, exp, erdy);
            if (rdy === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (first != DEPTH + 1) begin
            errors++;
            $display("FAIL clear_len: first out_ready after cycle %0d, want %0d", first, DEPTH + 1);
        end
        checks++;
        if (got !== s) begin
            errors++;
            $display("FAIL first_out: out=%h, want %h", got, s);
        end
    endtask

    task automatic test_impulse();
        logic [15:0] got, exp;
        logic rdy, erdy;
        logic [15:0] res[1000];
        int idx[4] = '{0, 256, 512, 768};
        logic [15:0] val[4] = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
        int nonzero = 0;
        reset_and_clear();
        for (int i = 0; i < 1000; i++) begin
            tick(1'b1, (i == 0) ? 16'h4000 : 16'h0, 1'b0, 1'b0, got, rdy, exp, erdy);
            res[i] = got;
            checks++;
            if (got !== exp || rdy !== erdy) begin
                errors++;
                $display("FAIL impulse[%0d]: out=%h rdy=%b, want %h/%b", i, got, rdy, exp, erdy);
            end
            if (i != 0 && i != 256 && i != 512 && i != 768 && got !== 16'h0) nonzero++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (res[idx[k]] !== val[k]) begin
                errors++;
                $display("FAIL impulse_tap%0d: out=%h, want %h", idx[k], res[idx[k]], val[k]);
            end
        end
        checks++;
        if (nonzero != 0) begin
            errors++;
            $display("FAIL impulse_quiet: %0d nonzero samples, want 0", nonzero);
        end
    endtask

    task automatic test_settings();
        logic [15:0] got, exp;
        logic rdy, erdy;
        logic [15:0] res[1100];
        logic [2:0] nd_seq[8] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000};
        reset_and_clear();
        // next_D held for three cycles must count once.
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 16'h0, nd_seq[i][0], nd_seq[i][1], got, rdy, exp, erdy);
            checks++;
            if (got !== exp || rdy !== erdy) begin
                errors++;
                $display("FAIL settings_idle[%0d]: out=%h rdy=%b, want %h/%b", i, got, rdy, exp, erdy);
            end
        end
        for (int i = 0; i < 1100; i++) begin
            tick(1'b1, (i == 0) ? 16'h4000 : 16'h0, 1'b0, 1'b0, got, rdy, exp, erdy);
            res[i] = got;
            checks++;
            if (got !== exp || rdy !== erdy) begin
                errors++;
                $display("FAIL settings[%0d]: out=%h rdy=%b, want %h/%b", i, got, rdy, exp, erdy);
            end
        end
        checks++;
        if (res[256] !== 16'h0 || res[512] !== 16'h0800 || res[1024] !== 16'h0100) begin
            errors++;
            $display("FAIL settings_taps: out256=%h out512=%h out1024=%h, want 0000/0800/0100",
                     res[256], res[512], res[1024]);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] got, exp;
        logic rdy, erdy;
        logic [15:0] at256 = '0;
`ifdef ECHO_SATURATE_EN
        logic [15:0] want256 = 16'h7FFF;
`else
        logic [15:0] want256 = 16'hA800;
`endif
        reset_and_clear();
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 16'h7000, 1'b0, 1'b0, got, rdy, exp, erdy);
            if (i == 256) at256 = got;
            checks++;
            if (got !== exp || rdy !== erdy) begin
                errors++;
                $display("FAIL sat[%0d]: out=%h rdy=%b, want %h/%b", i, got, rdy, exp, erdy);
            end
        end
        checks++;
        if (at256 !== want256) begin
            errors++;
            $display("FAIL sat_256: out=%h, want %h", at256, want256);
        end
    endtask

    task automatic test_random();
        logic [15:0] got, exp;
        logic rdy, erdy, v, nd, nh;
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            nd = ($urandom_range(0, 29) == 0);
            nh = ($urandom_range(0, 29) == 0);
            tick(v, 16'($urandom), nd, nh, got, rdy, exp, erdy);
            checks++;
            if (got !== exp || rdy !== erdy) begin
                errors++;
                $display("FAIL random[%0d]: out=%h rdy=%b, want %h/%b", i, got, rdy, exp, erdy);
            end
        end
    endtask

    task automatic test_toggle_reset();
        logic [15:0] got, exp, s;
        logic rdy, erdy, v;
        int run_len = 25;
        int left = 25;
        int ticks_cleared = 0;
        reset_and_clear();
        // in_ready flips about every 255 ns (25/26 cycles); sample alternates per accepted sample.
        v = 1'b1;
        s = 16'h0001;
        for (int i = 0; i < 1500; i++) begin
            tick(v, s, 1'b0, 1'b0, got, rdy, exp, erdy);
            checks++;
            if (got !== exp || rdy !== erdy) begin
                errors++;
                $display("FAIL toggle[%0d]: out=%h rdy=%b, want %h/%b", i, got, rdy, exp, erdy);
            end
            if (v) s = s ^ 16'h0001;
            left--;
            if (left == 0) begin
                v = ~v;
                run_len = (run_len == 25) ? 26 : 25;
                left = run_len;
            end
        end
        in_ready = 1'b1;
        #3 reset = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0 || out_ready !== 1'b0) begin
            errors++;
            $display("FAIL midstream_reset: out=%h out_ready=%b, want 0000/0", out, out_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, 16'($urandom), 1'b0, 1'b0, got, rdy, exp, erdy);
            if (rdy === 1'b0) ticks_cleared++;
        end
        checks++;
        if (ticks_cleared != DEPTH) begin
            errors++;
            $display("FAIL reclear: %0d silent cycles, want %0d", ticks_cleared, DEPTH);
        end
        for (int i = 0; i < 50; i++) begin
            tick(1'b1, 16'($urandom), 1'b0, 1'b0, got, rdy, exp, erdy);
            checks++;
            if (got !== exp || rdy !== erdy) begin
                errors++;
                $display("FAIL after_reset[%0d]: out=%h rdy=%b, want %h/%b", i, got, rdy, exp, erdy);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clear_latency();
        test_impulse();
        test_settings();
        test_saturation();
        test_random();
        test_toggle_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
